global_bram_responder: RTL and testbench



---
 rtl/global_bram_responder_pkg.sv | 37 +++
 rtl/global_bram_responder_bram_sp_128.sv | 39 +++
 rtl/global_bram_responder.sv | 152 +++++++++++++++
 tb/tb_global_bram_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/global_bram_responder_pkg.sv
// -----------------------------------------------------------------------------
// global_mem_pkg
// Shared types and address decode for the global BRAM responder.
//   WORD_W / ADDR_W / BYTE_SHIFT : word width, byte-address width, byte->word shift
//   mem_word_t                   : one 128-bit array word
//   rd_req_t                     : decoded request (valid, word index, out-of-range)
//   decode_addr()                : byte address -> word index + range check
// -----------------------------------------------------------------------------
package global_mem_pkg;

    localparam int WORD_W     = 128;
    localparam int ADDR_W     = 32;
    localparam int BYTE_SHIFT = 4;

    typedef logic [WORD_W-1:0] mem_word_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] index;
        logic              oob;
    } rd_req_t;

    // The subtraction wraps for addresses below base, so the explicit
    // addr < base test is needed in addition to the index bound.
    function automatic rd_req_t decode_addr(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] base,
                                            input logic [ADDR_W-1:0] depth);
        rd_req_t           r;
        logic [ADDR_W-1:0] idx;
        idx     = (addr - base) >> BYTE_SHIFT;
        r.valid = 1'b1;
        r.index = idx;
        r.oob   = (addr < base) || (idx >= depth);
        return r;
    endfunction

endpackage

// File: rtl/global_bram_responder_bram_sp_128.sv
// -----------------------------------------------------------------------------
// bram_sp_128
// Single-port, write-first 128-bit word array with one registered output,
// written so synthesis maps it onto block RAM. Contents have no reset.
//   clk  : clock
//   en   : port enable (read or write this cycle)
//   we   : write enable (qualified by en)
//   addr : word index
//   din  : write data
//   dout : registered read data, valid the cycle after an enabled read
// -----------------------------------------------------------------------------
module bram_sp_128
    import global_mem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  mem_word_t        din,
    output mem_word_t        dout
);

    mem_word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                dout      <= din;
            end else begin
                dout      <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/global_bram_responder.sv
// -----------------------------------------------------------------------------
// global_bram_responder
// Memory-side responder for the global BRAM request interface. Serves reads
// and writes from the fused control unit against a single-port 128-bit array,
// returning read data in request order RD_LAT cycles after the read issues.
// Arbitration per cycle: write > held read > new read. A read that collides
// with a write is parked in a one-entry hold register and issues later.
//   clk, reset          : clock, asynchronous active-high reset
//   start_read/addr_read: read strobe and byte address
//   start_write/addr_write/data_in : write strobe, byte address, data
//   data_out/data_valid : returned read word and its qualifier
//   rd_stall            : hold register occupied
//   addr_err            : sticky, a request fell outside the mapped range
//   ovf_err             : sticky, a read was dropped with the hold full
//   wr_count            : in-range writes committed since reset (wraps)
// INIT_FILE names a preload image for the implementation flow's memory
// initialisation step; the RTL leaves array contents undefined.
// -----------------------------------------------------------------------------
module global_bram_responder
    import global_mem_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          RD_LAT    = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_read,
    input  logic [ADDR_W-1:0] addr_read,
    input  logic              start_write,
    input  logic [ADDR_W-1:0] addr_write,
    input  mem_word_t         data_in,
    output mem_word_t         data_out,
    output logic              data_valid,
    output logic              rd_stall,
    output logic              addr_err,
    output logic              ovf_err,
    output logic [31:0]       wr_count
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
    localparam bit                unused_init_file = (INIT_FILE != "");

    rd_req_t           rd_dec, wr_dec, rd_new;
    rd_req_t           hold_q, hold_d;
    logic              issue_vld_p0, issue_oob_p0;
    logic [ADDR_W-1:0] issue_idx_p0;
    logic              wr_ok, rd_drop;
    logic              mem_en, mem_we;
    logic [IDX_W-1:0]  mem_addr;
    mem_word_t         rd_data_p1;
    mem_word_t         data_last;
    logic [RD_LAT-1:0] vld_pn, oob_pn;

    assign rd_dec = decode_addr(addr_read,  BASE_ADDR, DEPTH_W);
    assign wr_dec = decode_addr(addr_write, BASE_ADDR, DEPTH_W);
    assign rd_new = '{valid: start_read, index: rd_dec.index, oob: rd_dec.oob};

    logic unused_bits;
    assign unused_bits = ^{wr_dec.index[ADDR_W-1:IDX_W], issue_idx_p0[ADDR_W-1:IDX_W],
                           wr_dec.valid, rd_dec.valid, unused_init_file};

    // Stage p0: arbitration and array access
    always_comb begin
        hold_d       = hold_q;
        issue_vld_p0 = 1'b0;
        issue_oob_p0 = 1'b0;
        issue_idx_p0 = '0;
        wr_ok        = 1'b0;
        rd_drop      = 1'b0;
        if (start_write) begin
            wr_ok = !wr_dec.oob;
            if (start_read) begin
                if (hold_q.valid) rd_drop = 1'b1;
                else              hold_d  = rd_new;
            end
        end else if (hold_q.valid) begin
            issue_vld_p0 = 1'b1;
            issue_oob_p0 = hold_q.oob;
            issue_idx_p0 = hold_q.index;
            hold_d       = start_read ? rd_new : '0;
        end else if (start_read) begin
            issue_vld_p0 = 1'b1;
            issue_oob_p0 = rd_dec.oob;
            issue_idx_p0 = rd_dec.index;
        end
    end

    // Blocking the write while reset is high keeps a write coincident with
    // reset assertion out of the array.
    assign mem_we   = wr_ok && !reset;
    assign mem_en   = mem_we || (issue_vld_p0 && !issue_oob_p0);
    assign mem_addr = mem_we ? wr_dec.index[IDX_W-1:0] : issue_idx_p0[IDX_W-1:0];

    bram_sp_128 #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bram (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (data_in),
        .dout (rd_data_p1)
    );

    // Stage p1..pN: control pipeline, hold register and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q   <= '0;
            vld_pn   <= '0;
            oob_pn   <= '0;
            addr_err <= 1'b0;
            ovf_err  <= 1'b0;
            wr_count <= '0;
        end else begin
            hold_q    <= hold_d;
            vld_pn[0] <= issue_vld_p0;
            oob_pn[0] <= issue_oob_p0;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pn[k] <= vld_pn[k-1];
                oob_pn[k] <= oob_pn[k-1];
            end
            if ((start_read && rd_dec.oob) || (start_write && wr_dec.oob)) addr_err <= 1'b1;
            if (rd_drop) ovf_err <= 1'b1;
            if (wr_ok)   wr_count <= wr_count + 32'd1;
        end
    end

    // Stage p2..pN: data delay behind the array output register
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign data_last = rd_data_p1;
        end else begin : g_latn
            mem_word_t data_pn [RD_LAT-1];
            always_ff @(posedge clk) begin
                data_pn[0] <= rd_data_p1;
                for (int k = 1; k < RD_LAT - 1; k++) data_pn[k] <= data_pn[k-1];
            end
            assign data_last = data_pn[RD_LAT-2];
        end
    endgenerate

    // Out-of-range reads and idle cycles present zero; this also gives the
    // zero value on data_out straight out of reset.
    assign data_valid = vld_pn[RD_LAT-1];
    assign data_out   = (vld_pn[RD_LAT-1] && !oob_pn[RD_LAT-1]) ? data_last : '0;
    assign rd_stall   = hold_q.valid;

endmodule

// File: tb/tb_global_bram_responder.sv
// -----------------------------------------------------------------------------
// tb_global_bram_responder
// Scoreboard bench: each read pushes its expected word and return cycle;
// a negedge monitor pops and compares whenever data_valid is high.
// -----------------------------------------------------------------------------
module tb_global_bram_responder;
    import global_mem_pkg::*;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_read, start_write;
    logic [31:0] addr_read, addr_write;
    mem_word_t   data_in, data_out;
    logic        data_valid, rd_stall, addr_err, ovf_err;
    logic [31:0] wr_count;

    global_bram_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0),
        .RD_LAT    (RD_LAT),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_read  (start_read),
        .addr_read   (addr_read),
        .start_write (start_write),
        .addr_write  (addr_write),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .rd_stall    (rd_stall),
        .addr_err    (addr_err),
        .ovf_err     (ovf_err),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [127:0] PAT0F = {16{8'h0F}};
    localparam logic [127:0] PATAA = {16{8'hAA}};
    localparam logic [127:0] D90   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] DA0   = 128'hCAFE_0000_BEEF_0000_1234_5678_9ABC_DEF0;
    localparam logic [127:0] DTOP  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sr, input logic [31:0] ar,
                         input logic sw, input logic [31:0] aw, input logic [127:0] d);
        start_read  = sr;
        addr_read   = ar;
        start_write = sw;
        addr_write  = aw;
        data_in     = d;
        @(posedge clk);
        #1;
        start_read  = 1'b0;
        start_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [127:0] d);
        drive(1'b0, 32'h0, 1'b1, a, d);
    endtask

    // Direct read with no write pending: returns RD_LAT cycles after issue.
    task automatic rd(input logic [31:0] a, input logic [127:0] exp);
        sb.push_back('{exp, cyc + RD_LAT});
        drive(1'b1, a, 1'b0, 32'h0, '0);
    endtask

    task automatic chk_reset_state();
        chk("rst_data_out",   data_out,   '0);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_rd_stall",   rd_stall,   1'b0);
        chk("rst_addr_err",   addr_err,   1'b0);
        chk("rst_ovf_err",    ovf_err,    1'b0);
        chk("rst_wr_count",   wr_count,   32'd0);
    endtask

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid data_out=%h cyc=%0d", data_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rd_data", data_out, mon_e.data);
                chk("rd_cycle", 128'(cyc), 128'(mon_e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        logic stall_seen;
        reset = 1'b0; start_read = 1'b0; start_write = 1'b0;
        addr_read = '0; addr_write = '0; data_in = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_state();

        // write then read next cycle
        wr(32'h40, PAT0F);
        rd(32'h40, PAT0F);
        idle(4);
        chk("t1_wr_count", wr_count, 32'd1);

        // preload words 0..7 with their index, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) wr(32'(i * 16), 128'(i));
        stall_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(32'(i * 16), 128'(i));
            stall_seen |= rd_stall;
        end
        idle(4);
        chk("t2_no_stall", stall_seen, 1'b0);
        chk("t2_wr_count", wr_count, 32'd9);

        // same-cycle read and write of one word: read parked, sees new data
        c = cyc;
        sb.push_back('{PATAA, c + RD_LAT + 1});
        drive(1'b1, 32'h80, 1'b1, 32'h80, PATAA);
        chk("t3_stall_on", rd_stall, 1'b1);
        idle(1);
        chk("t3_stall_off", rd_stall, 1'b0);
        idle(4);
        chk("t3_wr_count", wr_count, 32'd10);

        // two read+write cycles in a row: second read dropped
        chk("t4_ovf_pre", ovf_err, 1'b0);
        c = cyc;
        sb.push_back('{128'd0, c + RD_LAT + 2});
        drive(1'b1, 32'h00, 1'b1, 32'h90, D90);
        drive(1'b1, 32'h10, 1'b1, 32'hA0, DA0);
        chk("t4_ovf_set", ovf_err, 1'b1);
        chk("t4_stall_held", rd_stall, 1'b1);
        idle(6);
        chk("t4_ovf_sticky", ovf_err, 1'b1);
        chk("t4_wr_count", wr_count, 32'd12);
        rd(32'h90, D90);
        rd(32'hA0, DA0);
        idle(4);

        // range boundaries
        chk("t5_addr_err_pre", addr_err, 1'b0);
        wr(32'((DEPTH - 1) * 16), DTOP);
        rd(32'((DEPTH - 1) * 16), DTOP);
        idle(4);
        chk("t5_addr_err_inrange", addr_err, 1'b0);
        rd(32'(DEPTH * 16), 128'd0);
        wr(32'hFFFF_FFF0, PAT0F);
        idle(4);
        chk("t5_addr_err", addr_err, 1'b1);
        chk("t5_wr_count", wr_count, 32'd13);

        // reset with reads in flight and a write coincident with reset
        drive(1'b1, 32'h40, 1'b0, 32'h0, '0);
        drive(1'b1, 32'h10, 1'b0, 32'h0, '0);
        start_write = 1'b1;
        addr_write  = 32'h30;
        data_in     = 128'hDEAD;
        reset       = 1'b1;
        @(posedge clk);
        #1 start_write = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_state();
        idle(4);
        chk("t6_quiet_valid", data_valid, 1'b0);
        rd(32'h40, 128'd4);
        rd(32'h30, 128'd3);
        rd(32'h80, PATAA);
        idle(5);
        chk("t6_wr_count", wr_count, 32'd0);

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
